// File: rtl/pmem_requester_if.sv
// Bundles the upstream request bus and the 256-bit line memory port of pmem_requester.
// master: the requester's view (drives memory strobes); slave: the cache/arbiter plus memory side.
interface pmem_requester_if;
    logic         up_read;
    logic         up_write;
    logic [31:0]  up_address;
    logic [255:0] up_wdata;
    logic         up_busy;
    logic         up_resp;
    logic         up_error;
    logic [255:0] up_rdata;

    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic         pmem_resp;
    logic         pmem_error;
    logic [255:0] pmem_rdata;

    modport master (
        input  up_read, up_write, up_address, up_wdata,
        input  pmem_resp, pmem_error, pmem_rdata,
        output up_busy, up_resp, up_error, up_rdata,
        output pmem_read, pmem_write, pmem_address, pmem_wdata
    );

    modport slave (
        output up_read, up_write, up_address, up_wdata,
        output pmem_resp, pmem_error, pmem_rdata,
        input  up_busy, up_resp, up_error, up_rdata,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata
    );
endinterface

// File: rtl/pmem_requester.sv
// One-at-a-time line request sequencer holding memory strobes stable for a whole transaction.
// Optional watchdog: define PMEM_REQUESTER_TIMEOUT_EN to abort REQ after TIMEOUT_CYCLES cycles.
module pmem_requester #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    pmem_requester_if.master  bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic         r_up_busy,    w_up_busy_nxt;
    logic         r_up_resp,    w_up_resp_nxt;
    logic         r_up_error,   w_up_error_nxt;
    logic [255:0] r_up_rdata,   w_up_rdata_nxt;
    logic         r_pmem_read,  w_pmem_read_nxt;
    logic         r_pmem_write, w_pmem_write_nxt;
    logic [31:0]  r_pmem_addr,  w_pmem_addr_nxt;
    logic [255:0] r_pmem_wdata, w_pmem_wdata_nxt;
    logic         r_err_sticky, w_err_sticky_nxt;

    logic w_accept;
    logic w_timeout;
    logic w_unused_addr_lsb;

    assign w_accept          = (r_state == S_IDLE) && (bus.up_read || bus.up_write);
    assign w_unused_addr_lsb = ^bus.up_address[4:0];

`ifdef PMEM_REQUESTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_cnt;

    // Counts REQ cycles without a response; the last one before the limit triggers the abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= '0;
        end else if (r_state == S_REQ && !bus.pmem_resp) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign w_timeout = (r_state == S_REQ) && !bus.pmem_resp &&
                       (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic w_unused_timeout_cfg;

    assign w_unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign w_timeout            = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_nxt = S_REQ;
            S_REQ:  if (bus.pmem_resp || w_timeout) w_state_nxt = S_DONE;
            S_DONE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_up_busy_nxt    = r_up_busy;
        w_up_resp_nxt    = 1'b0;
        w_up_error_nxt   = r_up_error;
        w_up_rdata_nxt   = r_up_rdata;
        w_pmem_read_nxt  = r_pmem_read;
        w_pmem_write_nxt = r_pmem_write;
        w_pmem_addr_nxt  = r_pmem_addr;
        w_pmem_wdata_nxt = r_pmem_wdata;
        w_err_sticky_nxt = r_err_sticky;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_up_busy_nxt    = 1'b1;
                    w_pmem_write_nxt = bus.up_write;
                    w_pmem_read_nxt  = !bus.up_write;
                    w_pmem_addr_nxt  = {bus.up_address[31:5], 5'b0};
                    w_err_sticky_nxt = 1'b0;
                    if (bus.up_write) w_pmem_wdata_nxt = bus.up_wdata;
                end
            end
            S_REQ: begin
                if (bus.pmem_error) w_err_sticky_nxt = 1'b1;
                if (bus.pmem_resp) begin
                    w_up_rdata_nxt   = bus.pmem_rdata;
                    w_up_error_nxt   = r_err_sticky | bus.pmem_error;
                    w_up_resp_nxt    = 1'b1;
                    w_pmem_read_nxt  = 1'b0;
                    w_pmem_write_nxt = 1'b0;
                end else if (w_timeout) begin
                    w_up_error_nxt   = 1'b1;
                    w_up_resp_nxt    = 1'b1;
                    w_pmem_read_nxt  = 1'b0;
                    w_pmem_write_nxt = 1'b0;
                end
            end
            S_DONE: begin
                w_up_busy_nxt = 1'b0;
            end
            default: begin
                w_up_busy_nxt = 1'b0;
            end
        endcase
    end

    // NOTE: the wide line registers are reset too, since they are visible outputs that must read 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_up_busy    <= 1'b0;
            r_up_resp    <= 1'b0;
            r_up_error   <= 1'b0;
            r_up_rdata   <= '0;
            r_pmem_read  <= 1'b0;
            r_pmem_write <= 1'b0;
            r_pmem_addr  <= '0;
            r_pmem_wdata <= '0;
            r_err_sticky <= 1'b0;
        end else begin
            r_up_busy    <= w_up_busy_nxt;
            r_up_resp    <= w_up_resp_nxt;
            r_up_error   <= w_up_error_nxt;
            r_up_rdata   <= w_up_rdata_nxt;
            r_pmem_read  <= w_pmem_read_nxt;
            r_pmem_write <= w_pmem_write_nxt;
            r_pmem_addr  <= w_pmem_addr_nxt;
            r_pmem_wdata <= w_pmem_wdata_nxt;
            r_err_sticky <= w_err_sticky_nxt;
        end
    end

    assign bus.up_busy      = r_up_busy;
    assign bus.up_resp      = r_up_resp;
    assign bus.up_error     = r_up_error;
    assign bus.up_rdata     = r_up_rdata;
    assign bus.pmem_read    = r_pmem_read;
    assign bus.pmem_write   = r_pmem_write;
    assign bus.pmem_address = r_pmem_addr;
    assign bus.pmem_wdata   = r_pmem_wdata;

endmodule

// File: tb/tb_pmem_requester.sv
// Directed bench for pmem_requester: a vector table of single transactions plus
// hand-written sequences for back-to-back turnaround, idle responses, timeout and reset.
module tb_pmem_requester;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    pmem_requester_if bus ();

    pmem_requester #(.TIMEOUT_CYCLES(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [255:0] exp_wdata;
    logic [255:0] exp_rdata;

    localparam logic [255:0] LINE_A5   = {32{8'hA5}};
    localparam logic [255:0] LINE_DB   = {8{32'hDEAD_BEEF}};
    localparam logic [255:0] LINE_1234 = {8{32'h1234_5678}};
    localparam logic [255:0] LINE_0F   = {8{32'h0F0F_0F0F}};
    localparam logic [255:0] LINE_CAFE = {8{32'hCAFE_F00D}};
    localparam logic [255:0] LINE_77   = {32{8'h77}};

    typedef struct {
        string        name;
        logic         rd;
        logic         wr;
        logic [31:0]  addr;
        logic [255:0] wdata;
        int           lat;
        int           err_at;
        logic [255:0] mem_rdata;
        logic [31:0]  exp_addr;
        logic         exp_wr;
        logic         exp_err;
    } vec_t;

    vec_t vecs[5];

    task automatic check_b(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_v(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_idle_outputs_zero(input string name);
        check_b({name, ".busy"}, bus.up_busy, 1'b0);
        check_b({name, ".resp"}, bus.up_resp, 1'b0);
        check_b({name, ".error"}, bus.up_error, 1'b0);
        check_v({name, ".rdata"}, bus.up_rdata, '0);
        check_b({name, ".pread"}, bus.pmem_read, 1'b0);
        check_b({name, ".pwrite"}, bus.pmem_write, 1'b0);
        check_v({name, ".paddr"}, {224'd0, bus.pmem_address}, '0);
        check_v({name, ".pwdata"}, bus.pmem_wdata, '0);
    endtask

    // Presents one request, lets memory answer after v.lat REQ cycles, checks every cycle.
    task automatic run_vec(input vec_t v);
        @(negedge clk);
        bus.up_read    = v.rd;
        bus.up_write   = v.wr;
        bus.up_address = v.addr;
        bus.up_wdata   = v.wdata;
        if (v.wr) exp_wdata = v.wdata;
        for (int k = 1; k <= v.lat; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus.up_read    = 1'b0;
                bus.up_write   = 1'b0;
                bus.up_address = ~v.addr;
                bus.up_wdata   = ~v.wdata;
            end
            check_b({v.name, ".req_busy"}, bus.up_busy, 1'b1);
            check_b({v.name, ".req_resp"}, bus.up_resp, 1'b0);
            check_b({v.name, ".req_pread"}, bus.pmem_read, !v.exp_wr);
            check_b({v.name, ".req_pwrite"}, bus.pmem_write, v.exp_wr);
            check_v({v.name, ".req_paddr"}, {224'd0, bus.pmem_address}, {224'd0, v.exp_addr});
            check_v({v.name, ".req_pwdata"}, bus.pmem_wdata, exp_wdata);
            bus.pmem_resp  = (k == v.lat);
            bus.pmem_error = (k == v.err_at);
            bus.pmem_rdata = (k == v.lat) ? v.mem_rdata : ~v.mem_rdata;
        end
        @(negedge clk);
        bus.pmem_resp  = 1'b0;
        bus.pmem_error = 1'b0;
        exp_rdata      = v.mem_rdata;
        check_b({v.name, ".done_resp"}, bus.up_resp, 1'b1);
        check_b({v.name, ".done_error"}, bus.up_error, v.exp_err);
        check_v({v.name, ".done_rdata"}, bus.up_rdata, exp_rdata);
        check_b({v.name, ".done_busy"}, bus.up_busy, 1'b1);
        check_b({v.name, ".done_pread"}, bus.pmem_read, 1'b0);
        check_b({v.name, ".done_pwrite"}, bus.pmem_write, 1'b0);
        @(negedge clk);
        check_b({v.name, ".idle_resp"}, bus.up_resp, 1'b0);
        check_b({v.name, ".idle_busy"}, bus.up_busy, 1'b0);
        check_v({v.name, ".idle_rdata"}, bus.up_rdata, exp_rdata);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t rv;

        vecs[0] = '{"rd_1234", 1'b1, 1'b0, 32'h0000_1234, LINE_1234, 3, 0, LINE_A5,
                    32'h0000_1220, 1'b0, 1'b0};
        vecs[1] = '{"wr_40", 1'b0, 1'b1, 32'h0000_0040, LINE_DB, 2, 0, LINE_77,
                    32'h0000_0040, 1'b1, 1'b0};
        vecs[2] = '{"both_ffff", 1'b1, 1'b1, 32'hFFFF_FFFF, LINE_1234, 1, 0, LINE_0F,
                    32'hFFFF_FFE0, 1'b1, 1'b0};
        vecs[3] = '{"rd_err_early", 1'b1, 1'b0, 32'h8000_001F, LINE_DB, 4, 2, LINE_CAFE,
                    32'h8000_0000, 1'b0, 1'b1};
        vecs[4] = '{"rd_err_at_resp", 1'b1, 1'b0, 32'h0000_0020, LINE_DB, 1, 1, LINE_A5,
                    32'h0000_0020, 1'b0, 1'b1};

        bus.up_read    = 1'b0;
        bus.up_write   = 1'b0;
        bus.up_address = '0;
        bus.up_wdata   = '0;
        bus.pmem_resp  = 1'b0;
        bus.pmem_error = 1'b0;
        bus.pmem_rdata = '0;
        exp_wdata      = '0;
        exp_rdata      = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle_outputs_zero("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Write then read with upstream held: strobes low through DONE and IDLE, read at R+2.
        @(negedge clk);
        bus.up_write   = 1'b1;
        bus.up_address = 32'h0000_0040;
        bus.up_wdata   = LINE_DB;
        exp_wdata      = LINE_DB;
        @(negedge clk);
        bus.up_write   = 1'b0;
        bus.up_read    = 1'b1;
        bus.up_address = 32'h0000_0047;
        bus.up_wdata   = ~LINE_DB;
        check_b("b2b.w1_pwrite", bus.pmem_write, 1'b1);
        check_v("b2b.w1_pwdata", bus.pmem_wdata, LINE_DB);
        @(negedge clk);
        bus.up_address = 32'h0000_0040;
        check_b("b2b.w2_pwrite", bus.pmem_write, 1'b1);
        check_v("b2b.w2_paddr", {224'd0, bus.pmem_address}, {224'd0, 32'h0000_0040});
        check_v("b2b.w2_pwdata", bus.pmem_wdata, LINE_DB);
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = '0;
        @(negedge clk);
        bus.pmem_resp = 1'b0;
        check_b("b2b.done_resp", bus.up_resp, 1'b1);
        check_b("b2b.done_pread", bus.pmem_read, 1'b0);
        check_b("b2b.done_pwrite", bus.pmem_write, 1'b0);
        @(negedge clk);
        check_b("b2b.idle_pread", bus.pmem_read, 1'b0);
        check_b("b2b.idle_busy", bus.up_busy, 1'b0);
        @(negedge clk);
        bus.up_read = 1'b0;
        check_b("b2b.r_pread", bus.pmem_read, 1'b1);
        check_b("b2b.r_pwrite", bus.pmem_write, 1'b0);
        check_b("b2b.r_busy", bus.up_busy, 1'b1);
        check_v("b2b.r_paddr", {224'd0, bus.pmem_address}, {224'd0, 32'h0000_0040});
        check_v("b2b.r_pwdata", bus.pmem_wdata, LINE_DB);
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = LINE_DB;
        @(negedge clk);
        bus.pmem_resp = 1'b0;
        exp_rdata     = LINE_DB;
        check_b("b2b.r_resp", bus.up_resp, 1'b1);
        check_b("b2b.r_error", bus.up_error, 1'b0);
        check_v("b2b.r_rdata", bus.up_rdata, exp_rdata);
        @(negedge clk);

        // A response while idle must be ignored.
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = LINE_CAFE;
        @(negedge clk);
        bus.pmem_resp = 1'b0;
        check_b("idle_resp.resp", bus.up_resp, 1'b0);
        check_b("idle_resp.busy", bus.up_busy, 1'b0);
        check_v("idle_resp.rdata", bus.up_rdata, exp_rdata);

`ifdef PMEM_REQUESTER_TIMEOUT_EN
        @(negedge clk);
        bus.up_read    = 1'b1;
        bus.up_address = 32'h0000_0200;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            bus.up_read = 1'b0;
            check_b($sformatf("tmo.c%0d_resp", k), bus.up_resp, 1'b0);
            check_b($sformatf("tmo.c%0d_pread", k), bus.pmem_read, 1'b1);
        end
        @(negedge clk);
        check_b("tmo.c9_resp", bus.up_resp, 1'b1);
        check_b("tmo.c9_error", bus.up_error, 1'b1);
        check_b("tmo.c9_pread", bus.pmem_read, 1'b0);
        check_v("tmo.c9_rdata", bus.up_rdata, exp_rdata);
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = LINE_A5;
        @(negedge clk);
        check_b("tmo.late1_resp", bus.up_resp, 1'b0);
        check_b("tmo.late1_busy", bus.up_busy, 1'b0);
        @(negedge clk);
        bus.pmem_resp = 1'b0;
        check_b("tmo.late2_resp", bus.up_resp, 1'b0);
        check_v("tmo.late2_rdata", bus.up_rdata, exp_rdata);
`endif

        // Asynchronous reset in the middle of REQ.
        @(negedge clk);
        bus.up_read    = 1'b1;
        bus.up_address = 32'h0000_0100;
        repeat (2) @(negedge clk);
        bus.up_read = 1'b0;
        check_b("rst.pre_pread", bus.pmem_read, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs_zero("rst.async");
        @(negedge clk);
        rst_n     = 1'b1;
        exp_wdata = '0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_b($sformatf("rst.after%0d_resp", k), bus.up_resp, 1'b0);
            check_b($sformatf("rst.after%0d_busy", k), bus.up_busy, 1'b0);
        end
        rv = '{"rst.new_rd", 1'b1, 1'b0, 32'h0000_0105, LINE_1234, 2, 0, LINE_0F,
               32'h0000_0100, 1'b0, 1'b0};
        run_vec(rv);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pmem_requester.md
# pmem_requester

Initiator-side sequencer for the 256-bit line physical memory port. It accepts one line request at a time from the cache/arbiter side and latches the request, so the upstream request does not need to be held. It drives `pmem_read`/`pmem_write`/`pmem_address`/`pmem_wdata` stable for the entire memory transaction, which the memory's change-detection rule requires. It returns the line and any error to the requester as a one-cycle completion pulse.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 1024: watchdog limit in cycles. Used only when `PMEM_REQUESTER_TIMEOUT_EN` is defined.

Ports:
- `clk`  in  1  single clock, all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `up_read`  in  1  line read request, sampled only in IDLE
- `up_write`  in  1  line write request, sampled only in IDLE
- `up_address`  in  32  byte address
- `up_wdata`  in  256  write line
- `up_busy`  out  1  high in REQ and DONE
- `up_resp`  out  1  one-cycle completion pulse
- `up_error`  out  1  valid with `up_resp`
- `up_rdata`  out  256  returned line, valid with `up_resp` and held afterwards
- `pmem_read`  out  1  to memory
- `pmem_write`  out  1  to memory
- `pmem_address`  out  32  to memory; line-aligned, bits [4:0] always 0
- `pmem_wdata`  out  256  to memory
- `pmem_resp`  in  1  memory response
- `pmem_error`  in  1  memory error flag
- `pmem_rdata`  in  256  memory read line

## Operation
- States: IDLE, REQ, DONE.
- **IDLE**
  - If `up_read|up_write` at an edge, latch the following and go to REQ:
    - the op: write if `up_write`, else read; write wins if both are high
    - `{up_address[31:5],5'b0}`
    - `up_wdata`, latched on writes only
  - Clear the sticky error flag on entry to REQ.
  - `pmem_resp` is ignored in IDLE.
- **REQ**
  - Exactly one of `pmem_read`/`pmem_write` is high.
  - Address, wdata and op are driven from the latch and never change.
  - Any cycle with `pmem_error`=1 sets the sticky error flag.
  - On an edge with `pmem_resp`=1:
    - capture `pmem_rdata` into `up_rdata`, for both reads and writes
    - `up_error` <= sticky flag OR `pmem_error`
    - `up_resp` <= 1
    - go to DONE
- **DONE**
  - `pmem_read`/`pmem_write` are 0; this is the memory's recovery cycle.
  - `up_resp` is high for this cycle only.
  - Upstream requests are not accepted.
  - Always go to IDLE next.
- All outputs are registered.
- **Reset** (`rst_n`=0, at any time including mid-REQ):
  - state IDLE
  - all outputs 0, including `up_rdata`, `pmem_address` and `pmem_wdata`
  - the latch and the sticky flag are cleared
  - The in-flight request is abandoned with no `up_resp`.

## Timing
- Upstream request sampled at edge E: `pmem_read`/`pmem_write` are high from E through the edge where `pmem_resp` is sampled (edge R).
- `up_resp` is high in the cycle after edge R.
- The next request can be sampled no earlier than edge R+2. The turnaround is one dead cycle with memory strobes low.
- Requests asserted while `up_busy`=1 are ignored, not queued; upstream re-presents them.
- Completion latency from acceptance is the memory latency plus 1 cycle.

## Configuration
- `PMEM_REQUESTER_TIMEOUT_EN` defined:
  - A cycle counter runs in REQ, cleared on entry.
  - If it reaches `TIMEOUT_CYCLES` without `pmem_resp`, go to DONE with `up_resp`=1 and `up_error`=1; `up_rdata` is unchanged.
  - Strobes drop in DONE as normal.
  - A late `pmem_resp` arriving in DONE or IDLE is ignored.
- Not defined: no counter. REQ waits indefinitely; `TIMEOUT_CYCLES` is unused.

## Test plan
- **Read:** `up_read`, addr 0x0000_1234 -> `pmem_address`=0x0000_1220 and `pmem_read` held stable. On `pmem_resp` with rdata=0xA5..A5, `up_resp` pulses one cycle with `up_rdata`=0xA5..A5 and `up_error`=0.
- **Write then read back-to-back:** write line 0xDEAD..BEEF to 0x40, then read 0x40 with upstream held -> `pmem_write` held with unchanged wdata; one dead cycle with strobes low; read returns 0xDEAD..BEEF.
- **Simultaneous `up_read`+`up_write`:** -> `pmem_write`=1, `pmem_read`=0.
- **Upstream input changes during REQ:** toggle `up_address` during REQ -> `pmem_address` unchanged. Pulse `pmem_error` for one cycle before `pmem_resp` -> `up_error`=1 with `up_resp`.
- **Timeout** (macro on, `TIMEOUT_CYCLES`=8): no `pmem_resp` -> `up_resp`=1 and `up_error`=1 in the 9th cycle after acceptance, strobes low. A later `pmem_resp` causes no second `up_resp`.
- **Reset mid-REQ:** assert `rst_n`=0 asynchronously -> all outputs 0 immediately. After release, no `up_resp`, and a new read completes normally.
